// File: rtl/dependence_arbiter.sv
// Round-robin arbiter sharing one 3-input evaluation unit between NUM_REQ requesters.
// Optional per-requester grant counters are enabled with DEPENDENCE_ARB_STATS_EN.
module dependence_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_abc,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   hold,
  output logic                   issue_valid,
  output logic                   issue_a,
  output logic                   issue_b,
  output logic                   issue_c,
  input  logic                   unit_q,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   rsp_q,
  output logic                   busy
`ifdef DEPENDENCE_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  stat_grants
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  typedef logic [PW-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t tag;
  } stage_t;

  idx_t               r_ptr;
  logic               r_issue_valid;
  logic [2:0]         r_issue_abc;
  idx_t               r_issue_tag;
  stage_t             r_pipe [LATENCY];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_q;

  logic               w_found;
  idx_t               w_winner;
  idx_t               w_idx;
  logic               w_grant;
  idx_t               w_ptr_next;
  logic [2:0]         w_abc_win;
  logic               w_pipe_any;

  // Scan from the priority pointer; the first valid requester wins.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = idx_t'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_grant    = w_found & ~hold & ~rst;
  assign req_ready  = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
  assign w_ptr_next = (w_winner == idx_t'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_abc_win  = req_abc[3*int'(w_winner) +: 3];

  // NOTE: state uses non-blocking assignments so each stage sees pre-edge values of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= '0;
      r_issue_valid <= 1'b0;
      r_issue_abc   <= '0;
      r_issue_tag   <= '0;
      // NOTE: tags are cleared with the valids; the pipe is tiny and this keeps outputs deterministic.
      for (int s = 0; s < LATENCY; s++) r_pipe[s] <= '0;
      r_rsp_valid   <= '0;
      r_rsp_q       <= 1'b0;
    end else begin
      r_issue_valid <= w_grant;
      if (w_grant) begin
        r_ptr       <= w_ptr_next;
        r_issue_abc <= w_abc_win;
        r_issue_tag <= w_winner;
      end
      r_pipe[0] <= {r_issue_valid, r_issue_tag};
      for (int s = 1; s < LATENCY; s++) r_pipe[s] <= r_pipe[s-1];
      // The last stage lines up with the cycle in which unit_q belongs to its tag.
      if (r_pipe[LATENCY-1].valid) begin
        r_rsp_valid <= NUM_REQ'(1) << r_pipe[LATENCY-1].tag;
        r_rsp_q     <= unit_q;
      end else begin
        r_rsp_valid <= '0;
      end
    end
  end

  always_comb begin
    w_pipe_any = 1'b0;
    for (int s = 0; s < LATENCY; s++) w_pipe_any = w_pipe_any | r_pipe[s].valid;
  end

  assign issue_valid = r_issue_valid;
  assign issue_a     = r_issue_abc[2];
  assign issue_b     = r_issue_abc[1];
  assign issue_c     = r_issue_abc[0];
  assign rsp_valid   = r_rsp_valid;
  assign rsp_q       = r_rsp_q;
  assign busy        = r_issue_valid | w_pipe_any | (|r_rsp_valid);

`ifdef DEPENDENCE_ARB_STATS_EN
  logic [15:0] r_stat [NUM_REQ];

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant && w_winner == idx_t'(i) && r_stat[i] != 16'hFFFF) r_stat[i] <= r_stat[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[16*i +: 16] = r_stat[i];
  end
`endif

endmodule
